// File: rtl/wb_stage.sv
// Writeback stage: MEM->WB register, load alignment/extension with stall hold, regfile write drive.
// Define WB_FWD_EN to drive the fwd_* bypass ports; otherwise they are tied to zero.
module wb_stage #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              m_valid,
  input  logic [DWIDTH-1:0] m_inst,
  input  logic [DWIDTH-1:0] m_alu,
  input  logic [DWIDTH-1:0] m_pc4,
  input  logic [DWIDTH-1:0] dmem_dout,
  input  logic [DWIDTH-1:0] uart_dout,
  output logic              rf_we,
  output logic [4:0]        rf_wa,
  output logic [DWIDTH-1:0] rf_wd,
  output logic [DWIDTH-1:0] wb_inst,
  output logic              fwd_valid,
  output logic [4:0]        fwd_rd,
  output logic [DWIDTH-1:0] fwd_data
);

  localparam logic [DWIDTH-1:0] NOP = 'h13;

  localparam logic [4:0] OPC_LOAD  = 5'b00000;
  localparam logic [4:0] OPC_OPIMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC = 5'b00101;
  localparam logic [4:0] OPC_OP    = 5'b01100;
  localparam logic [4:0] OPC_LUI   = 5'b01101;
  localparam logic [4:0] OPC_JALR  = 5'b11001;
  localparam logic [4:0] OPC_JAL   = 5'b11011;

  logic              vld_p0;
  logic              fresh_p0;
  logic [DWIDTH-1:0] inst_p0;
  logic [DWIDTH-1:0] alu_p0;
  logic [DWIDTH-1:0] pc4_p0;
  logic [DWIDTH-1:0] ld_hold_p0;

  logic [DWIDTH-1:0] raw;
  logic [DWIDTH-1:0] ld_word;
  logic              wr_op;

  function automatic logic [DWIDTH-1:0] load_ext(input logic [2:0] f3,
                                                 input logic [1:0] off,
                                                 input logic [DWIDTH-1:0] w);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [DWIDTH-1:0]  r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = DWIDTH'(b);
      3'b100:  r = {{(DWIDTH-8){1'b0}}, b};
      3'b001:  r = DWIDTH'(h);
      3'b101:  r = {{(DWIDTH-16){1'b0}}, h};
      3'b010:  r = w;
      default: r = '0;
    endcase
    return r;
  endfunction

  // MEM -> WB boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      inst_p0  <= NOP;
      alu_p0   <= '0;
      pc4_p0   <= '0;
      fresh_p0 <= 1'b0;
    end else if (flush) begin
      vld_p0   <= 1'b0;
      inst_p0  <= NOP;
      fresh_p0 <= 1'b0;
    end else if (stall) begin
      fresh_p0 <= 1'b0;
    end else begin
      vld_p0   <= m_valid;
      inst_p0  <= m_inst;
      alu_p0   <= m_alu;
      pc4_p0   <= m_pc4;
      fresh_p0 <= 1'b1;
    end
  end

  // Memory read data is only valid in the fresh cycle, so capture it for any following stall.
  always_ff @(posedge clk) begin
    if (rst)
      ld_hold_p0 <= '0;
    else if (fresh_p0)
      ld_hold_p0 <= raw;
  end

  assign raw     = alu_p0[31] ? uart_dout : dmem_dout;
  assign ld_word = fresh_p0 ? raw : ld_hold_p0;

  always_comb begin
    wr_op = 1'b0;
    rf_wd = alu_p0;
    case (inst_p0[6:2])
      OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC: wr_op = 1'b1;
      OPC_LOAD: begin
        wr_op = 1'b1;
        rf_wd = load_ext(inst_p0[14:12], alu_p0[1:0], ld_word);
      end
      OPC_JAL, OPC_JALR: begin
        wr_op = 1'b1;
        rf_wd = pc4_p0;
      end
      default: wr_op = 1'b0;
    endcase
  end

  assign rf_wa   = inst_p0[11:7];
  assign rf_we   = vld_p0 & wr_op & (rf_wa != 5'd0);
  assign wb_inst = inst_p0;

`ifdef WB_FWD_EN
  assign fwd_valid = rf_we;
  assign fwd_rd    = rf_wa;
  assign fwd_data  = rf_wd;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = 5'd0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: driver queues expected writeback per cycle, monitor checks it.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, m_valid;
  logic [31:0] m_inst, m_alu, m_pc4, dmem_dout, uart_dout;
  logic        rf_we, fwd_valid;
  logic [4:0]  rf_wa, fwd_rd;
  logic [31:0] rf_wd, wb_inst, fwd_data;

  wb_stage #(.DWIDTH(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .m_valid(m_valid),
    .m_inst(m_inst), .m_alu(m_alu), .m_pc4(m_pc4),
    .dmem_dout(dmem_dout), .uart_dout(uart_dout),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .wb_inst(wb_inst),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        chkwd;
    logic [31:0] inst;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] ADDI_X5 = 32'h0000_0293;
  localparam logic [31:0] LB_X6   = 32'h0000_0303;
  localparam logic [31:0] LH_X6   = 32'h0000_1303;
  localparam logic [31:0] LW_X6   = 32'h0000_2303;
  localparam logic [31:0] LBU_X6  = 32'h0000_4303;
  localparam logic [31:0] LHU_X6  = 32'h0000_5303;
  localparam logic [31:0] JAL_X1  = 32'h0000_00EF;
  localparam logic [31:0] SW      = 32'h0000_2323;
  localparam logic [31:0] ADD_X7  = 32'h0000_03B3;

  // One cycle of stimulus; the expectation applies after the next rising edge.
  task automatic step(input string nm, input logic r, input logic st, input logic fl,
                      input logic v, input logic [31:0] inst, input logic [31:0] alu,
                      input logic [31:0] pc4, input logic [31:0] dm, input logic [31:0] ua,
                      input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd,
                      input logic chk, input logic [31:0] einst);
    exp_t e;
    @(negedge clk);
    rst = r; stall = st; flush = fl; m_valid = v;
    m_inst = inst; m_alu = alu; m_pc4 = pc4; dmem_dout = dm; uart_dout = ua;
    e.cyc = cyc + 1; e.name = nm; e.we = ewe; e.wa = ewa; e.wd = ewd;
    e.chkwd = chk; e.inst = einst;
    q.push_back(e);
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    logic ok, fok;
    cyc <= cyc + 1;
    #1;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      ok = (rf_we === e.we) && (rf_wa === e.wa) && (wb_inst === e.inst) &&
           (!e.chkwd || rf_wd === e.wd) && (e.cyc == cyc);
`ifdef WB_FWD_EN
      fok = (fwd_valid === e.we) && (fwd_rd === e.wa) && (!e.chkwd || fwd_data === e.wd);
`else
      fok = (fwd_valid === 1'b0) && (fwd_rd === 5'd0) && (fwd_data === 32'd0);
`endif
      total++;
      if (!(ok && fok)) begin
        bad++;
        $display("FAIL %s: got we=%0b wa=%0d wd=%h inst=%h fwd=%0b/%0d/%h, want we=%0b wa=%0d wd=%h inst=%h",
                 e.name, rf_we, rf_wa, rf_wd, wb_inst, fwd_valid, fwd_rd, fwd_data,
                 e.we, e.wa, e.wd, e.inst);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; m_valid = 1'b0;
    m_inst = NOP; m_alu = '0; m_pc4 = '0; dmem_dout = '0; uart_dout = '0;

    //    name         rst st fl v  inst     alu            pc4            dmem           uart           we wa wd             chk inst
    step("reset0",     1, 0, 0, 0, NOP,     32'h0,         32'h0,         32'h0,         32'h0,         0, 0, 32'h0,         1, NOP);
    step("reset1",     1, 0, 0, 0, NOP,     32'h0,         32'h0,         32'h0,         32'h0,         0, 0, 32'h0,         1, NOP);
    step("release",    0, 0, 0, 0, NOP,     32'h0,         32'h0,         32'h0,         32'h0,         0, 0, 32'h0,         1, NOP);
    step("addi_x5",    0, 0, 0, 1, ADDI_X5, 32'h0000_1234, 32'h0,         32'h0,         32'h0,         1, 5, 32'h0000_1234, 1, ADDI_X5);
    step("addi_stall", 0, 1, 0, 1, NOP,     32'h0,         32'h0,         32'h0,         32'h0,         1, 5, 32'h0000_1234, 1, ADDI_X5);
    step("addi_x0",    0, 0, 0, 1, NOP,     32'h0000_1234, 32'h0,         32'h0,         32'h0,         0, 0, 32'h0000_1234, 1, NOP);
    step("bubble",     0, 0, 0, 0, ADDI_X5, 32'h0000_0055, 32'h0,         32'h0,         32'h0,         0, 5, 32'h0000_0055, 1, ADDI_X5);
    step("lb_3",       0, 0, 0, 1, LB_X6,   32'h0000_0103, 32'h0,         32'h80FF_7F01, 32'h0,         1, 6, 32'hFFFF_FF80, 1, LB_X6);
    step("lbu_3",      0, 0, 0, 1, LBU_X6,  32'h0000_0103, 32'h0,         32'h80FF_7F01, 32'h0,         1, 6, 32'h0000_0080, 1, LBU_X6);
    step("lh_2",       0, 0, 0, 1, LH_X6,   32'h0000_0102, 32'h0,         32'h80FF_7F01, 32'h0,         1, 6, 32'hFFFF_80FF, 1, LH_X6);
    step("lh_3",       0, 0, 0, 1, LH_X6,   32'h0000_0103, 32'h0,         32'h80FF_7F01, 32'h0,         1, 6, 32'hFFFF_80FF, 1, LH_X6);
    step("lhu_0",      0, 0, 0, 1, LHU_X6,  32'h0000_0100, 32'h0,         32'h80FF_7F01, 32'h0,         1, 6, 32'h0000_7F01, 1, LHU_X6);
    step("lw",         0, 0, 0, 1, LW_X6,   32'h0000_0101, 32'h0,         32'h80FF_7F01, 32'h0,         1, 6, 32'h80FF_7F01, 1, LW_X6);
    step("lw_hold0",   0, 0, 0, 1, LW_X6,   32'h0000_0200, 32'h0,         32'hDEAD_BEEF, 32'h0,         1, 6, 32'hDEAD_BEEF, 1, LW_X6);
    step("lw_hold1",   0, 1, 0, 1, ADD_X7,  32'h0000_0777, 32'h0,         32'hDEAD_BEEF, 32'h0,         1, 6, 32'hDEAD_BEEF, 1, LW_X6);
    step("lw_hold2",   0, 1, 0, 1, ADD_X7,  32'h0000_0777, 32'h0,         32'h1111_1111, 32'h2222_2222, 1, 6, 32'hDEAD_BEEF, 1, LW_X6);
    step("lw_hold3",   0, 1, 0, 1, ADD_X7,  32'h0000_0777, 32'h0,         32'h1111_1111, 32'h2222_2222, 1, 6, 32'hDEAD_BEEF, 1, LW_X6);
    step("uart_lbu",   0, 0, 0, 1, LBU_X6,  32'h8000_0004, 32'h0,         32'hFFFF_FFFF, 32'h0000_0041, 1, 6, 32'h0000_0041, 1, LBU_X6);
    step("jal_x1",     0, 0, 0, 1, JAL_X1,  32'h0000_0F00, 32'h1000_0008, 32'h0,         32'h0,         1, 1, 32'h1000_0008, 1, JAL_X1);
    step("sw",         0, 0, 0, 1, SW,      32'h0000_0010, 32'h0,         32'h0,         32'h0,         0, 6, 32'h0,         0, SW);
    step("add_x7",     0, 0, 0, 1, ADD_X7,  32'h0000_0099, 32'h0,         32'h0,         32'h0,         1, 7, 32'h0000_0099, 1, ADD_X7);
    step("flush_stall",0, 1, 1, 1, ADDI_X5, 32'h0000_0123, 32'h0,         32'h0,         32'h0,         0, 0, 32'h0,         0, NOP);
    step("after_flush",0, 0, 0, 0, NOP,     32'h0,         32'h0,         32'h0,         32'h0,         0, 0, 32'h0,         1, NOP);

    repeat (4) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got pending=%0d, want pending=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
